// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
//   Bundles the PS/2 pin pair and the decoded outputs of ps2_key_decoder.
//   master : board/testbench side. It drives the PS/2 pins and observes the decoded results.
//   slave  : decoder side. It samples the PS/2 pins and drives the decoded results.
//   Signals:
//     ps2_clk, ps2_data     raw PS/2 pins, asynchronous to the system clock
//     scan_code, prev_data  last two good bytes received
//     code_valid            one-cycle strobe when scan_code/prev_data update
//     click .. eight        one-cycle action pulses, one per physical key press
//     parity_error          one-cycle pulse when a frame is discarded for bad parity
//     frame_error           one-cycle pulse for a bad stop bit or a timeout abort
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic [7:0] prev_data;
  logic       code_valid;
  logic       click;
  logic       buy;
  logic       upgrade_click;
  logic       one;
  logic       two;
  logic       three;
  logic       four;
  logic       five;
  logic       six;
  logic       seven;
  logic       eight;
  logic       parity_error;
  logic       frame_error;

  modport master (
    output ps2_clk, ps2_data,
    input  scan_code, prev_data, code_valid,
    input  click, buy, upgrade_click,
    input  one, two, three, four, five, six, seven, eight,
    input  parity_error, frame_error
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output scan_code, prev_data, code_valid,
    output click, buy, upgrade_click,
    output one, two, three, four, five, six, seven, eight,
    output parity_error, frame_error
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Turns the PS/2 keyboard serial stream into one clean action pulse per
//   physical key press. It also exports the last two good bytes, so break
//   sequences can be detected downstream.
//   Typematic repeats, break sequences and extended-key sequences do not
//   produce action pulses.
//   Ports:
//     clock  system clock
//     reset  synchronous, active-high
//     bus    ps2_key_decoder_if.slave (PS/2 pins in, decoded outputs out)
//
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data 0 on a filtered falling edge)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | latching the parity bit
//   ST_STOP   | checking the stop bit, then evaluating the frame
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              clock,
  input logic              reset,
  ps2_key_decoder_if.slave bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic          clk_meta, clk_sync, data_meta, data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;

  logic          break_pending, ext_pending;
  logic [10:0]   key_down;
  logic [10:0]   key_onehot;
  logic          key_hit;

  logic [7:0]    scan_code, prev_data;
  logic          code_valid, parity_error, frame_error;
  logic [10:0]   action;

  // Two-flop synchronizers. They idle high to match the idle PS/2 bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= bus.ps2_clk;
      clk_sync  <= clk_meta;
      data_meta <= bus.ps2_data;
      data_sync <= data_meta;
    end
  end

  // filt_cnt counts consecutive synchronized samples that disagree with the
  // filtered level. The level flips on the FILTER_LEN-th such sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      clk_filt <= clk_sync;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // The falling edge is flagged in the same cycle the filtered level commits to 0.
  assign fall = clk_filt & ~clk_sync & (filt_cnt == FILT_LAST);

  // Bit order: click, buy, upgrade_click, one .. eight.
  always_comb begin
    key_onehot = '0;
    case (shift)
      8'h29:   key_onehot[0]  = 1'b1;
      8'h32:   key_onehot[1]  = 1'b1;
      8'h3C:   key_onehot[2]  = 1'b1;
      8'h16:   key_onehot[3]  = 1'b1;
      8'h1E:   key_onehot[4]  = 1'b1;
      8'h26:   key_onehot[5]  = 1'b1;
      8'h25:   key_onehot[6]  = 1'b1;
      8'h2E:   key_onehot[7]  = 1'b1;
      8'h36:   key_onehot[8]  = 1'b1;
      8'h3D:   key_onehot[9]  = 1'b1;
      8'h3E:   key_onehot[10] = 1'b1;
      default: key_onehot     = '0;
    endcase
  end

  assign key_hit = |key_onehot;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      parity_bit    <= 1'b0;
      to_cnt        <= '0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      key_down      <= '0;
      scan_code     <= '0;
      prev_data     <= '0;
      code_valid    <= 1'b0;
      parity_error  <= 1'b0;
      frame_error   <= 1'b0;
      action        <= '0;
    end else begin
      code_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      action       <= '0;

      if (state != ST_IDLE && !fall) begin
        // The frame is stalled. Abort once a full timeout has passed with no edge.
        if (to_cnt == TO_LAST) begin
          state       <= ST_IDLE;
          frame_error <= 1'b1;
          to_cnt      <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (fall && !data_sync) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end
          ST_DATA: begin
            shift   <= {data_sync, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            parity_bit <= data_sync;
            state      <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!data_sync) begin
              frame_error <= 1'b1;
            end else if (~^{shift, parity_bit}) begin
              parity_error <= 1'b1;
            end else begin
              code_valid <= 1'b1;
              scan_code  <= shift;
              prev_data  <= scan_code;
              if (shift == 8'hF0) begin
                break_pending <= 1'b1;
              end else if (shift == 8'hE0) begin
                ext_pending <= 1'b1;
              end else begin
                break_pending <= 1'b0;
                ext_pending   <= 1'b0;
                // Extended sequences leave key_down untouched.
                if (!ext_pending && key_hit) begin
                  if (break_pending) begin
                    key_down <= key_down & ~key_onehot;
                  end else if ((key_down & key_onehot) == '0) begin
                    key_down <= key_down | key_onehot;
                    action   <= key_onehot;
                  end
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.scan_code     = scan_code;
  assign bus.prev_data     = prev_data;
  assign bus.code_valid    = code_valid;
  assign bus.parity_error  = parity_error;
  assign bus.frame_error   = frame_error;
  assign bus.click         = action[0];
  assign bus.buy           = action[1];
  assign bus.upgrade_click = action[2];
  assign bus.one           = action[3];
  assign bus.two           = action[4];
  assign bus.three         = action[5];
  assign bus.four          = action[6];
  assign bus.five          = action[7];
  assign bus.six           = action[8];
  assign bus.seven         = action[9];
  assign bus.eight         = action[10];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Drives PS/2 frames into ps2_key_decoder. A reference model predicts one
//   output event per frame: a good byte, a parity error or a frame error.
//   Every cycle, the compare process matches each strobe cycle against the
//   predicted events. Literal expectations pin key points of the sequence.
module tb_ps2_key_decoder;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ps2_key_decoder_if bus();

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic        cv;
    logic        pe;
    logic        fe;
    logic [10:0] act;
    logic [7:0]  scan;
    logic [7:0]  prev;
  } ev_t;

  // Action bit order: click, buy, upgrade_click, one .. eight.
  logic [7:0] key_tab [11] = '{8'h29, 8'h32, 8'h3C, 8'h16, 8'h1E, 8'h26,
                               8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

  ev_t  exp_q[$];
  int   total  = 0;
  int   passed = 0;
  bit   chk_en = 1'b0;
  int   act_cnt [11];
  int   pe_cnt = 0;
  int   fe_cnt = 0;

  logic [7:0] m_scan, m_prev, cur_scan, cur_prev;
  bit         m_brk, m_ext;
  bit         held [256];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_scan = 8'h00; m_prev = 8'h00; cur_scan = 8'h00; cur_prev = 8'h00;
    m_brk = 1'b0; m_ext = 1'b0;
    for (int i = 0; i < 256; i++) held[i] = 1'b0;
  endtask

  // Predicts the decoder's reaction to one complete frame.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    ev_t e;
    int  slot;
    e = '0;
    if (bad_stop) begin
      e.fe = 1'b1;
    end else if (bad_par) begin
      e.pe = 1'b1;
    end else begin
      e.cv   = 1'b1;
      m_prev = m_scan;
      m_scan = b;
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else begin
        slot = -1;
        for (int i = 0; i < 11; i++) if (key_tab[i] == b) slot = i;
        if (slot >= 0 && !m_ext) begin
          if (m_brk) held[b] = 1'b0;
          else if (!held[b]) begin
            held[b]     = 1'b1;
            e.act[slot] = 1'b1;
          end
        end
        m_brk = 1'b0;
        m_ext = 1'b0;
      end
    end
    e.scan = m_scan;
    e.prev = m_prev;
    exp_q.push_back(e);
  endtask

  task automatic ps2_bit(input logic v);
    bus.ps2_data = v;
    tick(HALF);
    bus.ps2_clk = 1'b0;
    tick(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0, input bit bad_stop = 1'b0);
    logic par;
    par = bad_par ? ^b : ~^b;
    model_frame(b, bad_par, bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(!bad_stop);
    bus.ps2_data = 1'b1;
    tick(HALF);
    drain("frame_drain", 100);
  endtask

  // Start bit plus n data bits, then the clock stays high.
  task automatic send_partial(input int n, input bit expect_timeout);
    logic [7:0] pat;
    pat = 8'b1101_1011;
    if (expect_timeout) exp_q.push_back('{cv: 1'b0, pe: 1'b0, fe: 1'b1, act: 11'd0,
                                          scan: m_scan, prev: m_prev});
    ps2_bit(1'b0);
    for (int i = 0; i < n; i++) ps2_bit(pat[i]);
    bus.ps2_data = 1'b1;
    if (expect_timeout) drain("timeout_drain", TIMEOUT_CYCLES + 300);
  endtask

  function automatic ev_t observe();
    ev_t o;
    o.cv   = bus.code_valid;
    o.pe   = bus.parity_error;
    o.fe   = bus.frame_error;
    o.act  = {bus.eight, bus.seven, bus.six, bus.five, bus.four, bus.three,
              bus.two, bus.one, bus.upgrade_click, bus.buy, bus.click};
    o.scan = bus.scan_code;
    o.prev = bus.prev_data;
    return o;
  endfunction

  always @(negedge clock) begin
    ev_t o, e;
    if (chk_en) begin
      o = observe();
      if (o.cv || o.pe || o.fe || (o.act != '0)) begin
        for (int i = 0; i < 11; i++) if (o.act[i]) act_cnt[i]++;
        if (o.pe) pe_cnt++;
        if (o.fe) fe_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_strobe got=%h exp=none", o);
        end else begin
          e = exp_q.pop_front();
          cur_scan = e.scan;
          cur_prev = e.prev;
          chk("event", o, e);
        end
      end
      chk("hold_bytes", {bus.scan_code, bus.prev_data}, {cur_scan, cur_prev});
    end
  end

  task automatic check_reset_values();
    chk("rst_scan", bus.scan_code, 8'h00);
    chk("rst_prev", bus.prev_data, 8'h00);
    chk("rst_strobes", observe(), '0);
  endtask

  initial begin
    for (int i = 0; i < 11; i++) act_cnt[i] = 0;
    model_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    tick(4);
    reset = 1'b0;
    tick(2);
    check_reset_values();
    chk_en = 1'b1;

    send_frame(8'h29);
    chk("make_scan", bus.scan_code, 8'h29);
    chk("make_prev", bus.prev_data, 8'h00);
    chk("click_once", act_cnt[0], 1);

    repeat (3) send_frame(8'h32);
    chk("buy_typematic", act_cnt[1], 1);
    send_frame(8'hF0);
    send_frame(8'h32);
    chk("brk_scan", bus.scan_code, 8'h32);
    chk("brk_prev", bus.prev_data, 8'hF0);
    chk("buy_after_brk", act_cnt[1], 1);
    send_frame(8'h32);
    chk("buy_repress", act_cnt[1], 2);

    send_frame(8'h16); send_frame(8'hF0); send_frame(8'h16);
    send_frame(8'h3E); send_frame(8'hF0); send_frame(8'h3E);
    chk("one_once", act_cnt[3], 1);
    chk("eight_once", act_cnt[10], 1);

    send_frame(8'h1E, 1'b1, 1'b0);
    chk("parity_err", pe_cnt, 1);
    chk("parity_scan", bus.scan_code, 8'h3E);
    chk("two_none", act_cnt[4], 0);
    send_frame(8'h25, 1'b0, 1'b1);
    chk("stop_err", fe_cnt, 1);
    chk("four_none", act_cnt[6], 0);

    send_partial(4, 1'b1);
    chk("timeout_err", fe_cnt, 2);
    send_frame(8'h3C);
    chk("upgrade_once", act_cnt[2], 1);

    send_frame(8'hF0); send_frame(8'h29);
    send_frame(8'hE0); send_frame(8'h29);
    chk("ext_no_click", act_cnt[0], 1);
    chk("ext_scan", bus.scan_code, 8'h29);
    chk("ext_prev", bus.prev_data, 8'hE0);
    send_frame(8'h29);
    chk("click_after_ext", act_cnt[0], 2);

    send_partial(3, 1'b0);
    chk_en = 1'b0;
    reset  = 1'b1;
    tick(3);
    reset  = 1'b0;
    model_reset();
    tick(1);
    check_reset_values();
    chk_en = 1'b1;
    send_frame(8'h26);
    chk("three_once", act_cnt[5], 1);
    chk("post_rst_scan", bus.scan_code, 8'h26);
    chk("post_rst_prev", bus.prev_data, 8'h00);
    chk("err_total", pe_cnt + fe_cnt, 3);

    tick(20);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
